// File: rtl/button_debouncer_if.sv
// Pad-side bundle for the push-button conditioner: raw pad input in, clean level
// and long-press flag out.
interface button_debouncer_if;
    logic button_raw;
    logic level_out;
    logic long_press_out;

    modport master (
        output button_raw,
        input  level_out,
        input  long_press_out
    );

    modport slave (
        input  button_raw,
        output level_out,
        output long_press_out
    );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises, polarity-normalises and debounces a mechanical push-button, and flags
// presses held longer than LONG_PRESS_CYCLES.
//
// state        | meaning
// LOW_STABLE   | released, level_out = 0
// RISE_PENDING | sync high, counting toward a confirmed press
// HIGH_STABLE  | pressed, level_out = 1, hold counter advancing
// FALL_PENDING | sync low, counting toward a confirmed release; hold counter frozen
module button_debouncer #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input logic          clock,
    input logic          reset_n,
    button_debouncer_if.slave btn
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;
    localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_TC = HW'((LONG_PRESS_CYCLES > 0) ? LONG_PRESS_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        LOW_STABLE   = 2'd0,
        RISE_PENDING = 2'd1,
        HIGH_STABLE  = 2'd2,
        FALL_PENDING = 2'd3
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q, dcnt_nxt;
    logic [HW-1:0]          hcnt_q, hcnt_nxt;
    logic                   level_q, level_nxt;
    logic                   long_q, long_nxt;
    logic                   sample;
    logic                   sync;

    // Reset value 0 in the chain is the released level after normalisation.
    assign sample = btn.button_raw ^ ACTIVE_LOW;
    assign sync   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= LOW_STABLE;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sample};
            state_q <= state_nxt;
            dcnt_q  <= dcnt_nxt;
            hcnt_q  <= hcnt_nxt;
            level_q <= level_nxt;
            long_q  <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            LOW_STABLE:   if (sync) state_nxt = RISE_PENDING;
            RISE_PENDING: begin
                if (!sync)               state_nxt = LOW_STABLE;
                else if (dcnt_q == D_TC) state_nxt = HIGH_STABLE;
            end
            HIGH_STABLE:  if (!sync) state_nxt = FALL_PENDING;
            FALL_PENDING: begin
                if (sync)                state_nxt = HIGH_STABLE;
                else if (dcnt_q == D_TC) state_nxt = LOW_STABLE;
            end
            default:      state_nxt = LOW_STABLE;
        endcase
    end

    always_comb begin
        dcnt_nxt  = dcnt_q;
        hcnt_nxt  = hcnt_q;
        level_nxt = level_q;
        long_nxt  = long_q;
        case (state_q)
            LOW_STABLE: begin
                dcnt_nxt = sync ? DW'(1) : '0;
            end
            RISE_PENDING: begin
                if (!sync) begin
                    dcnt_nxt = '0;
                end else if (dcnt_q == D_TC) begin
                    dcnt_nxt  = '0;
                    level_nxt = 1'b1;
                    hcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt_q + DW'(1);
                end
            end
            HIGH_STABLE: begin
                // A drop on the terminal-count edge wins over the long-press flag.
                if (!sync) begin
                    dcnt_nxt = DW'(1);
                end else if (LONG_PRESS_CYCLES > 0 && !long_q) begin
                    if (hcnt_q == H_TC) long_nxt = 1'b1;
                    else                hcnt_nxt = hcnt_q + HW'(1);
                end
            end
            FALL_PENDING: begin
                if (sync) begin
                    dcnt_nxt = '0;
                end else if (dcnt_q == D_TC) begin
                    dcnt_nxt  = '0;
                    level_nxt = 1'b0;
                    long_nxt  = 1'b0;
                end else begin
                    dcnt_nxt = dcnt_q + DW'(1);
                end
            end
            default: begin
                dcnt_nxt  = '0;
                level_nxt = 1'b0;
                long_nxt  = 1'b0;
            end
        endcase
    end

    assign btn.level_out      = level_q;
    assign btn.long_press_out = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance see the same
// press pattern and are both compared every edge against a run-length reference model.
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;
    int   edge_cnt;

    logic m_pipe[$];
    logic m_level;
    logic m_long;
    int   m_run;
    int   m_held;

    button_debouncer_if if0();
    button_debouncer_if if1();

    button_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .btn(if0.slave)
    );

    button_debouncer #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .btn(if1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, edge_cnt, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
        m_level  = 1'b0;
        m_long   = 1'b0;
        m_run    = 0;
        m_held   = 0;
        edge_cnt = 0;
    endtask

    // r is the pressed level; the active-low instance sees its complement on the pad.
    task automatic step(input logic r);
        logic s;
        if0.button_raw = r;
        if1.button_raw = ~r;
        @(posedge clock);
        edge_cnt++;
        s = m_pipe.pop_front();
        m_pipe.push_back(r);
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = s;
                m_run   = 0;
                if (s) m_held = 0;
                else   m_long = 1'b0;
            end
        end else begin
            if (m_level && m_run == 0 && !m_long) begin
                m_held++;
                if (m_held == LONG) m_long = 1'b1;
            end
            m_run = 0;
        end
        #1;
        check("level_ah", if0.level_out, m_level);
        check("long_ah", if0.long_press_out, m_long);
        check("level_al", if1.level_out, m_level);
        check("long_al", if1.long_press_out, m_long);
    endtask

    initial begin
        int rise_ah, rise_al, long_at, fall_at, long_clr_at, dropped;
        logic pat[7];
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        if0.button_raw = 1'b0;
        if1.button_raw = 1'b1;
        model_reset();

        #2;
        check("rst_level_ah", if0.level_out, 1'b0);
        check("rst_long_ah", if0.long_press_out, 1'b0);
        check("rst_level_al", if1.level_out, 1'b0);
        check("rst_long_al", if1.long_press_out, 1'b0);
        #10;
        reset_n = 1'b1;

        // clean press held through long press
        rise_ah = 0; rise_al = 0; long_at = 0;
        for (int i = 1; i <= 18; i++) begin
            step(1'b1);
            if (rise_ah == 0 && if0.level_out) rise_ah = i;
            if (rise_al == 0 && if1.level_out) rise_al = i;
            if (long_at == 0 && if0.long_press_out) long_at = i;
        end
        check_int("clean_rise_edge", rise_ah, SYNC + DEB);
        check_int("inv_rise_edge", rise_al, SYNC + DEB);
        check_int("long_edge", long_at, SYNC + DEB + LONG);

        // release after long press
        fall_at = 0; long_clr_at = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            if (fall_at == 0 && !if0.level_out) fall_at = i;
            if (long_clr_at == 0 && !if0.long_press_out) long_clr_at = i;
        end
        check_int("release_fall_edge", fall_at, SYNC + DEB);
        check_int("release_long_clr_edge", long_clr_at, SYNC + DEB);

        // press bounce
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(pat[i]);
            check("bounce_level", if0.level_out, 1'b0);
        end
        rise_ah = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1);
            if (rise_ah == 0 && if0.level_out) rise_ah = i;
        end
        check_int("bounce_rise_edge", rise_ah, SYNC + DEB);
        for (int i = 0; i < 8; i++) step(1'b0);

        // release bounce with hold counter at 5: sync low for two edges, then high again
        rise_ah = 0; long_at = 0; dropped = 0;
        for (int i = 1; i <= 22; i++) begin
            step((i == 10 || i == 11) ? 1'b0 : 1'b1);
            if (rise_ah == 0 && if0.level_out) rise_ah = i;
            if (rise_ah != 0 && !if0.level_out) dropped = 1;
            if (long_at == 0 && if0.long_press_out) long_at = i;
        end
        check_int("relbounce_rise_edge", rise_ah, SYNC + DEB);
        check_int("relbounce_level_held", dropped, 0);
        check_int("relbounce_long_edge", long_at, SYNC + DEB + LONG + 3);
        for (int i = 0; i < 8; i++) step(1'b0);

        // async reset mid-press with long press active
        for (int i = 0; i < 18; i++) step(1'b1);
        check("pre_rst_long", if0.long_press_out, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_level_ah", if0.level_out, 1'b0);
        check("async_long_ah", if0.long_press_out, 1'b0);
        check("async_level_al", if1.level_out, 1'b0);
        check("async_long_al", if1.long_press_out, 1'b0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        model_reset();
        rise_ah = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1);
            if (rise_ah == 0 && if0.level_out) rise_ah = i;
        end
        check_int("post_rst_rise_edge", rise_ah, SYNC + DEB);

        // randomised bursts: short ones exercise glitch rejection, long ones the hold path
        for (int b = 0; b < 80; b++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = (b % 3 == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) step(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
